// File: rtl/sata_identify_pkg.sv
// Shared types and constants for the IDENTIFY DEVICE data FIS parser.
package sata_identify_pkg;

    // FIS type of a DMA/PIO data FIS.
    localparam logic [7:0] DataFis = 8'h46;

    typedef enum logic [1:0] {StIdle, StBody, StDrop} state_e;

    // Default ATA word offsets of the extracted fields.
    localparam int unsigned SataCapWordDef = 76;
    localparam int unsigned QdepthWordDef  = 75;
    localparam int unsigned CmdsetWordDef  = 83;
    localparam int unsigned MaxLbaWordDef  = 100;

    // Integrity word: low byte carries the signature, high byte the checksum.
    localparam int unsigned IntegrityWord = 255;
    localparam logic [7:0]  IntegritySig  = 8'hA5;

    // Max LBA is kept at the full four-word width; the top slices it.
    typedef struct packed {
        logic        sata1;
        logic        sata2;
        logic        sata3;
        logic        ncq;
        logic [4:0]  queue_depth;
        logic        lba48;
        logic [63:0] max_lba;
    } sata_identify_t;

endpackage

// File: rtl/sata_identify_checksum.sv
// Running 8-bit byte sum over payload dwords.
module sata_identify_checksum (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic        acc_i,
    input  logic [31:0] dat_i,
    output logic [7:0]  sum_o
);

    logic [7:0] sum_q;

    // Result already includes the current beat so the eop dword is covered.
    assign sum_o = sum_q + dat_i[7:0] + dat_i[15:8] + dat_i[23:16] + dat_i[31:24];

    // Accumulator register, cleared at the start of each data FIS.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
        end else if (acc_i) begin
            sum_q <= sum_o;
        end
    end

endmodule

// File: rtl/sata_identify_parser_ext.sv
// IDENTIFY DEVICE data FIS parser: captures capability fields into shadow
// registers and commits them atomically on a clean frame end.
// Optional byte-sum integrity check: define SATA_IDENTIFY_INTEGRITY_EN.
module sata_identify_parser_ext
    import sata_identify_pkg::*;
#(
    parameter int unsigned PAYLOAD_DWORDS = 128,
    parameter int unsigned LBA_WIDTH      = 48,
    parameter int unsigned SATA_CAP_WORD  = SataCapWordDef,
    parameter int unsigned QDEPTH_WORD    = QdepthWordDef,
    parameter int unsigned CMDSET_WORD    = CmdsetWordDef,
    parameter int unsigned MAX_LBA_WORD   = MaxLbaWordDef
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          i_dat,
    input  logic                 i_val,
    input  logic                 i_eop,
    input  logic                 i_err,
    output logic                 identify_done,
    output logic                 identify_strobe,
    output logic                 sata1_supported,
    output logic                 sata2_supported,
    output logic                 sata3_supported,
    output logic                 ncq_supported,
    output logic [4:0]           queue_depth,
    output logic                 lba48_supported,
    output logic [LBA_WIDTH-1:0] max_lba_address,
    output logic                 bad_checksum,
    output logic                 bad_length,
    output logic                 bad_integrity
);

    localparam int unsigned PW = (PAYLOAD_DWORDS > 1) ? $clog2(PAYLOAD_DWORDS) : 1;
    localparam logic [PW-1:0] LastIdx = PW'(PAYLOAD_DWORDS - 1);
    localparam logic [PW-1:0] SataIdx = PW'(SATA_CAP_WORD / 2);
    localparam logic [PW-1:0] QdIdx   = PW'(QDEPTH_WORD / 2);
    localparam logic [PW-1:0] CmdIdx  = PW'(CMDSET_WORD / 2);
    localparam int unsigned SataOff = (SATA_CAP_WORD % 2) * 16;
    localparam int unsigned QdOff   = (QDEPTH_WORD % 2) * 16;
    localparam int unsigned CmdOff  = (CMDSET_WORD % 2) * 16;

    state_e         state_q, state_d;
    logic [PW-1:0]  p_q, p_d;
    logic           overrun_q, overrun_d;
    sata_identify_t shadow_q, shadow_d;
    sata_identify_t res_q, res_d;
    logic           done_q, done_d;
    logic           strobe_q, strobe_d;
    logic           bad_cksum_q, bad_cksum_d;
    logic           bad_len_q, bad_len_d;
    logic           bad_integ_q, bad_integ_d;
    logic           frame_start, payload_beat, integ_fail;
    logic           unused_lba;

    assign frame_start  = (state_q == StIdle) && i_val && !i_eop && (i_dat[7:0] == DataFis);
    assign payload_beat = (state_q == StBody) && i_val;

`ifdef SATA_IDENTIFY_INTEGRITY_EN
    localparam logic [PW-1:0] SigIdx = PW'(IntegrityWord / 2);
    localparam int unsigned   SigOff = (IntegrityWord % 2) * 16;
    localparam bit            SigInFrame = (IntegrityWord / 2) < PAYLOAD_DWORDS;

    logic       sig_q, sig_d;
    logic [7:0] cks_sum;

    sata_identify_checksum u_checksum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (frame_start),
        .acc_i   (payload_beat),
        .dat_i   (i_dat),
        .sum_o   (cks_sum)
    );

    // Track whether the signature byte has been seen in the current frame.
    always_comb begin
        sig_d = sig_q;
        if (frame_start) begin
            sig_d = 1'b0;
        end else if (payload_beat && SigInFrame && (p_q == SigIdx)) begin
            sig_d = (i_dat[SigOff +: 8] == IntegritySig);
        end
    end

    // Signature register.
    always_ff @(posedge clk) begin
        if (!reset_n) sig_q <= 1'b0;
        else          sig_q <= sig_d;
    end

    assign integ_fail = sig_d && (cks_sum != 8'h00);
`else
    assign integ_fail = 1'b0;
`endif

    // Shadow capture; a new data FIS starts from a clean shadow.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_start) begin
            shadow_d = '0;
        end else if (payload_beat) begin
            if (p_q == SataIdx) begin
                shadow_d.sata1 = i_dat[SataOff + 1];
                shadow_d.sata2 = i_dat[SataOff + 2];
                shadow_d.sata3 = i_dat[SataOff + 3];
                shadow_d.ncq   = i_dat[SataOff + 8];
            end
            // 5-bit wrap: raw 31 reports 0, meaning 32.
            if (p_q == QdIdx) shadow_d.queue_depth = i_dat[QdOff +: 5] + 5'd1;
            if (p_q == CmdIdx) shadow_d.lba48 = i_dat[CmdOff + 10];
            for (int k = 0; k < 4; k++) begin
                if (p_q == PW'((MAX_LBA_WORD + k) / 2)) begin
                    shadow_d.max_lba[16*k +: 16] = i_dat[((MAX_LBA_WORD + k) % 2) * 16 +: 16];
                end
            end
        end
    end

    // Frame FSM, termination flags and atomic commit.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        overrun_d   = overrun_q;
        res_d       = res_q;
        done_d      = done_q;
        strobe_d    = 1'b0;
        bad_cksum_d = bad_cksum_q;
        bad_len_d   = bad_len_q;
        bad_integ_d = bad_integ_q;
        unique case (state_q)
            StIdle: begin
                // Single-dword frames are ignored outright.
                if (i_val && !i_eop) begin
                    overrun_d = 1'b0;
                    if (frame_start) begin
                        state_d = StBody;
                        p_d     = '0;
                        done_d  = 1'b0;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StBody: begin
                if (i_val) begin
                    if (i_eop) begin
                        state_d     = StIdle;
                        bad_cksum_d = i_err;
                        bad_len_d   = (p_q != LastIdx);
                        bad_integ_d = integ_fail;
                        // Commit from shadow_d so a field in the eop dword counts.
                        if (!i_err && (p_q == LastIdx) && !integ_fail) begin
                            res_d    = shadow_d;
                            done_d   = 1'b1;
                            strobe_d = 1'b1;
                        end
                    end else if (p_q == LastIdx) begin
                        state_d   = StDrop;
                        overrun_d = 1'b1;
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end
            end
            StDrop: begin
                if (i_val && i_eop) begin
                    state_d   = StIdle;
                    overrun_d = 1'b0;
                    if (overrun_q) begin
                        bad_len_d   = 1'b1;
                        bad_cksum_d = i_err;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            p_q         <= '0;
            overrun_q   <= 1'b0;
            shadow_q    <= '0;
            res_q       <= '0;
            done_q      <= 1'b0;
            strobe_q    <= 1'b0;
            bad_cksum_q <= 1'b0;
            bad_len_q   <= 1'b0;
            bad_integ_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            overrun_q   <= overrun_d;
            shadow_q    <= shadow_d;
            res_q       <= res_d;
            done_q      <= done_d;
            strobe_q    <= strobe_d;
            bad_cksum_q <= bad_cksum_d;
            bad_len_q   <= bad_len_d;
            bad_integ_q <= bad_integ_d;
        end
    end

    assign identify_done   = done_q;
    assign identify_strobe = strobe_q;
    assign sata1_supported = res_q.sata1;
    assign sata2_supported = res_q.sata2;
    assign sata3_supported = res_q.sata3;
    assign ncq_supported   = res_q.ncq;
    assign queue_depth     = res_q.queue_depth;
    assign lba48_supported = res_q.lba48;
    assign max_lba_address = res_q.max_lba[LBA_WIDTH-1:0];
    assign bad_checksum    = bad_cksum_q;
    assign bad_length      = bad_len_q;
    // Stays 0 when the integrity check is compiled out.
    assign bad_integrity   = bad_integ_q;

    // LBA bits above LBA_WIDTH are never presented.
    assign unused_lba = ^res_q.max_lba;

endmodule

// File: tb/tb_sata_identify_parser_ext.sv
// Scoreboard bench for sata_identify_parser_ext (default parameters).
module tb_sata_identify_parser_ext;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] i_dat;
    logic        i_val, i_eop, i_err;
    logic        identify_done, identify_strobe;
    logic        sata1_supported, sata2_supported, sata3_supported, ncq_supported;
    logic [4:0]  queue_depth;
    logic        lba48_supported;
    logic [47:0] max_lba_address;
    logic        bad_checksum, bad_length, bad_integrity;

    always #5 clk = ~clk;

    sata_identify_parser_ext dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_dat           (i_dat),
        .i_val           (i_val),
        .i_eop           (i_eop),
        .i_err           (i_err),
        .identify_done   (identify_done),
        .identify_strobe (identify_strobe),
        .sata1_supported (sata1_supported),
        .sata2_supported (sata2_supported),
        .sata3_supported (sata3_supported),
        .ncq_supported   (ncq_supported),
        .queue_depth     (queue_depth),
        .lba48_supported (lba48_supported),
        .max_lba_address (max_lba_address),
        .bad_checksum    (bad_checksum),
        .bad_length      (bad_length),
        .bad_integrity   (bad_integrity)
    );

    typedef struct {
        bit        strobe, done, s1, s2, s3, ncq;
        bit [4:0]  qd;
        bit        lba48;
        bit [47:0] lba;
        bit        bc, bl, bi;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mdl;
    logic [15:0] words [256];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare the registered outputs on the cycle after each frame end.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("strobe", identify_strobe, e.strobe);
                check_eq("done", identify_done, e.done);
                check_eq("sata1", sata1_supported, e.s1);
                check_eq("sata2", sata2_supported, e.s2);
                check_eq("sata3", sata3_supported, e.s3);
                check_eq("ncq", ncq_supported, e.ncq);
                check_eq("qdepth", queue_depth, e.qd);
                check_eq("lba48", lba48_supported, e.lba48);
                check_eq("max_lba", max_lba_address, e.lba);
                check_eq("bad_checksum", bad_checksum, e.bc);
                check_eq("bad_length", bad_length, e.bl);
                check_eq("bad_integrity", bad_integrity, e.bi);
            end else begin
                check_eq("strobe_idle", identify_strobe, 1'b0);
            end
        end
    end

    task automatic check_all_zero();
        check_eq("rst_done", identify_done, 1'b0);
        check_eq("rst_strobe", identify_strobe, 1'b0);
        check_eq("rst_sata", {sata1_supported, sata2_supported, sata3_supported}, 3'b000);
        check_eq("rst_ncq", ncq_supported, 1'b0);
        check_eq("rst_qdepth", queue_depth, 5'd0);
        check_eq("rst_lba48", lba48_supported, 1'b0);
        check_eq("rst_max_lba", max_lba_address, 48'd0);
        check_eq("rst_flags", {bad_checksum, bad_length, bad_integrity}, 3'b000);
    endtask

    task automatic init_words();
        for (int w = 0; w < 256; w++) words[w] = {8'(w), ~8'(w)};
    endtask

    task automatic set_f1();
        init_words();
        words[76]  = 16'h000E;
        words[75]  = 16'h001F;
        words[83]  = 16'h0400;
        words[100] = 16'h6030;
        words[101] = 16'h3A38;
        words[102] = 16'h0000;
        words[103] = 16'h0000;
    endtask

    task automatic set_f2();
        init_words();
        words[76]  = 16'h0102;
        words[75]  = 16'h001E;
        words[83]  = 16'h0000;
        words[100] = 16'hDEF0;
        words[101] = 16'h9ABC;
        words[102] = 16'h5678;
        words[103] = 16'h1234;
    endtask

    function automatic logic [31:0] payload_dword(input int p);
        if (p < 128) return {words[2*p+1], words[2*p]};
        return 32'hDEAD_0000 | 32'(p);
    endfunction

    task automatic beat(input logic [31:0] d, input bit eop, input bit err);
        i_dat = d;
        i_val = 1'b1;
        i_eop = eop;
        i_err = eop ? err : 1'b0;
        @(posedge clk);
        #1;
        i_val = 1'b0;
        i_eop = 1'b0;
        i_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model of one frame end; pushes the expected output set.
    task automatic finish_frame(input int n, input logic [7:0] hdr, input bit err);
        exp_t       e;
        int         m;
        bit         commit;
        bit         integ;
        logic [7:0] sum;
        commit = 1'b0;
        integ  = 1'b0;
        sum    = 8'h00;
        if (n >= 2 && hdr == 8'h46) begin
            m = n - 1;
            mdl.done = 1'b0;
            if (m <= 128) begin
                mdl.bc = err;
                mdl.bl = (m != 128);
`ifdef SATA_IDENTIFY_INTEGRITY_EN
                if (m == 128 && words[255][7:0] == 8'hA5) begin
                    for (int w = 0; w < 256; w++) sum = sum + words[w][7:0] + words[w][15:8];
                    integ = (sum != 8'h00);
                end
                mdl.bi = integ;
`endif
                if (!err && m == 128 && !integ) begin
                    commit    = 1'b1;
                    mdl.done  = 1'b1;
                    mdl.s1    = words[76][1];
                    mdl.s2    = words[76][2];
                    mdl.s3    = words[76][3];
                    mdl.ncq   = words[76][8];
                    mdl.qd    = words[75][4:0] + 5'd1;
                    mdl.lba48 = words[83][10];
                    mdl.lba   = {words[102], words[101], words[100]};
                end
            end else begin
                mdl.bl = 1'b1;
                mdl.bc = err;
            end
        end
        e = mdl;
        e.strobe = commit;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input int n, input logic [7:0] hdr, input bit err, input bit gaps);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? {24'h0, hdr} : payload_dword(k - 1);
            if (gaps && (k % 7 == 3)) idle(1);
            beat(d, k == n - 1, err);
        end
        finish_frame(n, hdr, err);
    endtask

    task automatic clear_model();
        mdl = '{default: 0};
    endtask

`ifdef SATA_IDENTIFY_INTEGRITY_EN
    // Make the whole payload byte sum come to zero plus an offset.
    task automatic seal_words(input logic [7:0] offset);
        logic [7:0] s;
        s = 8'h00;
        words[255] = 16'h00A5;
        for (int w = 0; w < 256; w++) s = s + words[w][7:0] + words[w][15:8];
        words[255] = {8'h00 - s + offset, 8'hA5};
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        i_dat   = '0;
        i_val   = 1'b0;
        i_eop   = 1'b0;
        i_err   = 1'b0;
        clear_model();
        idle(3);
        mon_en = 1'b1;
        check_all_zero();
        reset_n = 1'b1;
        idle(2);

        set_f1();
        send_frame(129, 8'h46, 1'b0, 1'b0);   // clean commit
        send_frame(129, 8'h46, 1'b1, 1'b0);   // CRC error, no commit
        set_f2();
        send_frame(129, 8'h46, 1'b0, 1'b1);   // back-to-back, with idle gaps
        idle(2);
        send_frame(100, 8'h46, 1'b0, 1'b0);   // short frame
        send_frame(140, 8'h46, 1'b0, 1'b0);   // overrun
        send_frame(140, 8'h46, 1'b1, 1'b0);   // overrun with CRC error
        send_frame(5, 8'h34, 1'b0, 1'b0);     // register FIS dropped
        send_frame(1, 8'h46, 1'b0, 1'b0);     // single-dword frame ignored
        set_f1();
        send_frame(129, 8'h46, 1'b0, 1'b0);
        idle(2);

`ifdef SATA_IDENTIFY_INTEGRITY_EN
        set_f2();
        seal_words(8'h00);
        send_frame(129, 8'h46, 1'b0, 1'b0);   // signature, good sum
        set_f1();
        seal_words(8'h01);
        send_frame(129, 8'h46, 1'b0, 1'b0);   // off by one
        set_f1();
        words[255] = 16'h1200;
        send_frame(129, 8'h46, 1'b0, 1'b0);   // no signature
        idle(2);
`endif

        // Reset in the middle of a frame, then a full clean frame.
        set_f2();
        beat({24'h0, 8'h46}, 1'b0, 1'b0);
        for (int k = 1; k < 60; k++) beat(payload_dword(k - 1), 1'b0, 1'b0);
        reset_n = 1'b0;
        idle(2);
        check_all_zero();
        reset_n = 1'b1;
        clear_model();
        set_f1();
        send_frame(129, 8'h46, 1'b0, 1'b0);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) idle(1);
        check_eq("drain", exp_q.size(), 0);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
